// File: rtl/tage_resolve_queue.sv
// In-order queue pairing TAGE predictions with resolved outcomes; emits one-cycle
// predictor update pulses and keeps saturating retire/mispredict statistics.
module tage_resolve_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     pred_valid_i,
    input  logic                     pred_i,
    input  logic [31:0]              pred_idx_i,
    output logic                     pred_ready_o,
    input  logic                     res_valid_i,
    input  logic                     res_taken_i,
    input  logic [31:0]              res_idx_i,
    output logic                     res_ready_o,
    input  logic                     flush_i,
    output logic                     upd_valid_o,
    output logic                     upd_taken_o,
    output logic                     upd_mispredict_o,
    output logic [31:0]              upd_idx_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [CNT_W-1:0]         total_cnt_o,
    output logic [CNT_W-1:0]         mispred_cnt_o,
    output logic                     err_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      count_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic             pred_mem [DEPTH];
    logic [31:0]      idx_mem  [DEPTH];

    logic             push;
    logic             pop;
    logic             head_pred;
    logic [31:0]      head_idx;
    logic             mispredict;
    logic             idx_err;
    logic             drop_err;

    logic             upd_valid_q;
    logic             upd_taken_q;
    logic             upd_mispredict_q;
    logic [31:0]      upd_idx_q;
    logic [CNT_W-1:0] total_q;
    logic [CNT_W-1:0] mispred_q;
    logic             err_q;

    // Handshakes look only at registered occupancy, so a full queue refuses a push
    // even when a pop happens in the same cycle.
    assign pred_ready_o = (count_q != (AW+1)'(DEPTH));
    assign res_ready_o  = (count_q != '0);

    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        head_pred  = pred_mem[rd_ptr_q];
        head_idx   = idx_mem[rd_ptr_q];
        mispredict = 1'b0;
        idx_err    = 1'b0;
        drop_err   = 1'b0;
        if (!flush_i) begin
            push     = pred_valid_i && pred_ready_o;
            pop      = res_valid_i && res_ready_o;
            drop_err = res_valid_i && !res_ready_o;
        end
        if (pop) begin
            mispredict = (head_pred != res_taken_i);
            idx_err    = (head_idx != res_idx_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pred_mem[wr_ptr_q] <= pred_i;
            idx_mem[wr_ptr_q]  <= pred_idx_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            upd_valid_q      <= 1'b0;
            upd_taken_q      <= 1'b0;
            upd_mispredict_q <= 1'b0;
            upd_idx_q        <= '0;
        end else begin
            upd_valid_q <= pop;
            if (pop) begin
                upd_taken_q      <= res_taken_i;
                upd_mispredict_q <= mispredict;
                upd_idx_q        <= res_idx_i;
            end
        end
    end

    // Statistics stick at all-ones instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            total_q   <= '0;
            mispred_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (pop && (total_q != '1))
                total_q <= total_q + CNT_W'(1);
            if (pop && mispredict && (mispred_q != '1))
                mispred_q <= mispred_q + CNT_W'(1);
            if (idx_err || drop_err)
                err_q <= 1'b1;
        end
    end

    assign count_o          = count_q;
    assign upd_valid_o      = upd_valid_q;
    assign upd_taken_o      = upd_taken_q;
    assign upd_mispredict_o = upd_mispredict_q;
    assign upd_idx_o        = upd_idx_q;
    assign total_cnt_o      = total_q;
    assign mispred_cnt_o    = mispred_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_tage_resolve_queue.sv
// Scoreboard bench for tage_resolve_queue: a queue model predicts occupancy, statistics
// and error state, and expected update pulses are matched as the DUT emits them.
module tb_tage_resolve_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pred_valid = 1'b0;
    logic              pred = 1'b0;
    logic [31:0]       pred_idx = '0;
    logic              pred_ready;
    logic              res_valid = 1'b0;
    logic              res_taken = 1'b0;
    logic [31:0]       res_idx = '0;
    logic              res_ready;
    logic              flush = 1'b0;
    logic              upd_valid;
    logic              upd_taken;
    logic              upd_mispredict;
    logic [31:0]       upd_idx;
    logic [3:0]        count;
    logic [CNT_W-1:0]  total_cnt;
    logic [CNT_W-1:0]  mispred_cnt;
    logic              err;

    tage_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pred_valid_i    (pred_valid),
        .pred_i          (pred),
        .pred_idx_i      (pred_idx),
        .pred_ready_o    (pred_ready),
        .res_valid_i     (res_valid),
        .res_taken_i     (res_taken),
        .res_idx_i       (res_idx),
        .res_ready_o     (res_ready),
        .flush_i         (flush),
        .upd_valid_o     (upd_valid),
        .upd_taken_o     (upd_taken),
        .upd_mispredict_o(upd_mispredict),
        .upd_idx_o       (upd_idx),
        .count_o         (count),
        .total_cnt_o     (total_cnt),
        .mispred_cnt_o   (mispred_cnt),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    typedef struct { logic pred; logic [31:0] idx; } ent_t;
    typedef struct { logic taken; logic mis; logic [31:0] idx; } upd_t;

    ent_t m_q[$];
    upd_t sb[$];
    int   m_total = 0;
    int   m_mis   = 0;
    logic m_err   = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    // Update pulses are expected exactly one edge after the pop that caused them.
    always @(negedge clk) begin
        if (!rst) begin
            if (upd_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL upd_spurious: got upd_valid=1 idx=%h, required no pulse", upd_idx);
                end else begin
                    upd_t e;
                    e = sb.pop_front();
                    if (upd_taken !== e.taken || upd_mispredict !== e.mis || upd_idx !== e.idx) begin
                        miscompares++;
                        $display("FAIL upd_fields: got taken=%b mis=%b idx=%h, required taken=%b mis=%b idx=%h",
                                 upd_taken, upd_mispredict, upd_idx, e.taken, e.mis, e.idx);
                    end
                end
            end else if (sb.size() != 0) begin
                vectors++;
                miscompares++;
                $display("FAIL upd_missing: got upd_valid=0, required pulse idx=%h", sb[0].idx);
                sb.delete();
            end
        end
    end

    // Drives one cycle of inputs and advances the reference model at the edge.
    task automatic step(input logic pv, input logic p, input logic [31:0] pi,
                        input logic rv, input logic rt, input logic [31:0] ri,
                        input logic fl);
        logic m_push, m_pop;
        ent_t h;
        pred_valid = pv; pred = p; pred_idx = pi;
        res_valid = rv; res_taken = rt; res_idx = ri; flush = fl;
        @(posedge clk);
        m_push = pv && (m_q.size() != DEPTH);
        m_pop  = rv && (m_q.size() != 0);
        if (fl) begin
            m_q.delete();
        end else begin
            if (rv && !m_pop) m_err = 1'b1;
            if (m_pop) begin
                h = m_q.pop_front();
                sb.push_back('{taken: rt, mis: (h.pred != rt), idx: ri});
                if (m_total < CMAX) m_total++;
                if (h.pred != rt && m_mis < CMAX) m_mis++;
                if (h.idx != ri) m_err = 1'b1;
            end
            if (m_push) m_q.push_back('{pred: p, idx: pi});
        end
        @(negedge clk);
        #1;
        pred_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (count !== 4'd0 || pred_ready !== 1'b1 || res_ready !== 1'b0 || upd_valid !== 1'b0 ||
            upd_taken !== 1'b0 || upd_mispredict !== 1'b0 || upd_idx !== 32'h0 ||
            total_cnt !== '0 || mispred_cnt !== '0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got cnt=%0d prdy=%b rrdy=%b uv=%b ut=%b um=%b ui=%h tot=%0d mis=%0d err=%b, required all zero with prdy=1",
                     count, pred_ready, res_ready, upd_valid, upd_taken, upd_mispredict, upd_idx, total_cnt, mispred_cnt, err);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic();
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (res_ready !== 1'b1 || count !== 4'd1) begin
            miscompares++;
            $display("FAIL basic_push: got rrdy=%b cnt=%0d, required 1 1", res_ready, count);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 1'b0);
        vectors++;
        if (total_cnt !== 4'd1 || mispred_cnt !== 4'd1 || err !== 1'b0 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL basic_retire: got tot=%0d mis=%0d err=%b cnt=%0d, required 1 1 0 0",
                     total_cnt, mispred_cnt, err, count);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'(i % 2), 32'h200 + 32'(i * 4), 1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (count !== 4'd8 || pred_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_state: got cnt=%0d prdy=%b, required 8 0", count, pred_ready);
        end
        step(1'b1, 1'b1, 32'hdead, 1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (count !== 4'd8) begin
            miscompares++;
            $display("FAIL full_refuse: got cnt=%0d, required 8", count);
        end
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'(i % 3 == 0), 32'h200 + 32'(i * 4), 1'b0);
        vectors++;
        if (count !== 4'd0 || res_ready !== 1'b0 || total_cnt !== 4'(m_total) ||
            mispred_cnt !== 4'(m_mis) || err !== 1'b0) begin
            miscompares++;
            $display("FAIL full_drain: got cnt=%0d rrdy=%b tot=%0d mis=%0d err=%b, required 0 0 %0d %0d 0",
                     count, res_ready, total_cnt, mispred_cnt, err, m_total, m_mis);
        end
        // Pointers have wrapped; a fresh entry must still come back intact.
        step(1'b1, 1'b0, 32'h2f0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2f0, 1'b0);
        vectors++;
        if (err !== 1'b0 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL full_wrap: got err=%b cnt=%0d, required 0 0", err, count);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'(i == 1), 32'h400 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h403, 1'b1, 1'b1, 32'h400, 1'b0);
        vectors++;
        if (count !== 4'd3 || total_cnt !== 4'(m_total) || err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_count: got cnt=%0d tot=%0d err=%b, required 3 %0d 0", count, total_cnt, err, m_total);
        end
        for (int i = 1; i < 4; i++)
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h400 + 32'(i), 1'b0);
        vectors++;
        if (count !== 4'd0 || mispred_cnt !== 4'(m_mis) || total_cnt !== 4'(m_total)) begin
            miscompares++;
            $display("FAIL b2b_drain: got cnt=%0d mis=%0d tot=%0d, required 0 %0d %0d",
                     count, mispred_cnt, total_cnt, m_mis, m_total);
        end
    endtask

    task automatic test_empty_resolve();
        int t0, mi0;
        t0 = m_total; mi0 = m_mis;
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h500, 1'b0);
        vectors++;
        if (err !== 1'b1 || total_cnt !== 4'(t0) || mispred_cnt !== 4'(mi0)) begin
            miscompares++;
            $display("FAIL empty_resolve: got err=%b tot=%0d mis=%0d, required 1 %0d %0d", err, total_cnt, mispred_cnt, t0, mi0);
        end
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: got err=%b, required 1", err);
        end
    endtask

    task automatic test_flush();
        int t0, mi0;
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 32'h600 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
        t0 = m_total; mi0 = m_mis;
        step(1'b1, 1'b1, 32'h6ff, 1'b0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (count !== 4'd0 || res_ready !== 1'b0 || total_cnt !== 4'(t0) ||
            mispred_cnt !== 4'(mi0) || err !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_state: got cnt=%0d rrdy=%b tot=%0d mis=%0d err=%b, required 0 0 %0d %0d 1",
                     count, res_ready, total_cnt, mispred_cnt, err, t0, mi0);
        end
        step(1'b1, 1'b1, 32'h610, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h610, 1'b0);
        vectors++;
        if (count !== 4'd0 || total_cnt !== 4'(m_total)) begin
            miscompares++;
            $display("FAIL flush_resume: got cnt=%0d tot=%0d, required 0 %0d", count, total_cnt, m_total);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 20 && m_total < CMAX; i++) begin
            step(1'b1, 1'b1, 32'h700 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h700 + 32'(i), 1'b0);
        end
        vectors++;
        if (total_cnt !== 4'd15) begin
            miscompares++;
            $display("FAIL sat_reach: got tot=%0d, required 15", total_cnt);
        end
        step(1'b1, 1'b0, 32'h7f0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h7f0, 1'b0);
        vectors++;
        if (total_cnt !== 4'd15 || mispred_cnt !== 4'(m_mis)) begin
            miscompares++;
            $display("FAIL sat_hold: got tot=%0d mis=%0d, required 15 %0d", total_cnt, mispred_cnt, m_mis);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 32'h800, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h804, 1'b0, 1'b0, 32'h0, 1'b0);
        res_valid = 1'b1; res_taken = 1'b0; res_idx = 32'h800;
        @(posedge clk);
        #1;
        rst = 1'b1;
        res_valid = 1'b0;
        m_q.delete(); sb.delete();
        m_total = 0; m_mis = 0; m_err = 1'b0;
        #1;
        vectors++;
        if (upd_valid !== 1'b0 || count !== 4'd0 || res_ready !== 1'b0 || total_cnt !== '0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got uv=%b cnt=%0d rrdy=%b tot=%0d err=%b, required 0 0 0 0 0",
                     upd_valid, count, res_ready, total_cnt, err);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_idx_mismatch();
        step(1'b1, 1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h904, 1'b0);
        vectors++;
        if (err !== m_err || err !== 1'b1 || total_cnt !== 4'd1 || mispred_cnt !== 4'd0 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL idx_mismatch: got err=%b tot=%0d mis=%0d cnt=%0d, required 1 1 0 0",
                     err, total_cnt, mispred_cnt, count);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d pending updates, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_empty_resolve();
        test_flush();
        test_saturate();
        test_reset_mid();
        test_idx_mismatch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tage_resolve_queue.md
TAGE_RESOLVE_QUEUE -- requirements
Module: tage_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning in-flight prediction entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 32, meaning statistics counter width.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pred_valid_i  input  1  predictor offers a prediction this cycle.
REQ-006 SHALL have port pred_i  input  1  predicted direction (1 = taken).
REQ-007 SHALL have port pred_idx_i  input  32  branch address of the prediction.
REQ-008 SHALL have port pred_ready_o  output  1  queue can accept a prediction.
REQ-009 SHALL have port res_valid_i  input  1  branch outcome resolved this cycle.
REQ-010 SHALL have port res_taken_i  input  1  actual direction.
REQ-011 SHALL have port res_idx_i  input  32  branch address of the resolved branch.
REQ-012 SHALL have port res_ready_o  output  1  queue holds an entry to retire.
REQ-013 SHALL have port flush_i  input  1  discard all in-flight entries.
REQ-014 SHALL have port upd_valid_o  output  1  one-cycle update pulse to predictor tables.
REQ-015 SHALL have port upd_taken_o  output  1  resolved direction for the update.
REQ-016 SHALL have port upd_mispredict_o  output  1  stored prediction differed from outcome.
REQ-017 SHALL have port upd_idx_o  output  32  branch address for the update.
REQ-018 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-019 SHALL have port total_cnt_o  output  CNT_W  retired branches.
REQ-020 SHALL have port mispred_cnt_o  output  CNT_W  retired mispredicted branches.
REQ-021 SHALL have port err_o  output  1  sticky protocol error flag.

Function
REQ-022 SHALL be an in-order FIFO of {pred, idx}; pred_ready_o = (count_o != DEPTH), res_ready_o = (count_o != 0), both combinational from registered state only (no bypass).
REQ-023 SHALL push when pred_valid_i && pred_ready_o; write pointer wraps modulo DEPTH.
REQ-024 SHALL pop head when res_valid_i && res_ready_o; read pointer wraps modulo DEPTH.
REQ-025 SHALL allow simultaneous push and pop when 0 < count_o < DEPTH, leaving count_o unchanged; when full, only pop occurs (push refused); when empty, only push occurs.
REQ-026 SHALL, on pop, register in the next cycle: upd_valid_o=1, upd_taken_o=res_taken_i, upd_idx_o=res_idx_i, upd_mispredict_o=(head.pred != res_taken_i); upd_valid_o=0 in all other cycles; other upd_* hold last values.
REQ-027 SHALL increment total_cnt_o on every pop and mispred_cnt_o on every mispredicted pop, each saturating at all-ones.
REQ-028 SHALL set err_o when res_valid_i arrives with count_o==0 (outcome dropped, no update) or when a popped head idx != res_idx_i (pop and update still occur); err_o clears only on reset.
REQ-029 SHALL, on flush_i, set count_o=0 and both pointers to 0 next cycle, ignoring any same-cycle push or pop; counters and err_o are retained; no update pulse.
REQ-030 SHALL exhibit latency: prediction accepted cycle N becomes retirable (res_ready_o=1) at cycle N+1; update pulse appears cycle after pop.

Reset
REQ-031 SHALL, while rst_i=1, force count_o=0, pointers=0, upd_valid_o=0, upd_taken_o=0, upd_mispredict_o=0, upd_idx_o=0, total_cnt_o=0, mispred_cnt_o=0, err_o=0; hence pred_ready_o=1, res_ready_o=0.
REQ-032 SHALL discard all in-flight entries and any pending update pulse when reset asserts mid-operation.

Verification
REQ-033 Push (pred=1, idx=0x100), then resolve (taken=0, idx=0x100) -> next cycle upd_valid_o=1, upd_mispredict_o=1, total=1, mispred=1, err_o=0.
REQ-034 Push 8 entries with DEPTH=8 -> pred_ready_o=0, count_o=8; 9th push refused; then 8 matching resolves retire in order, count_o=0, pointers wrapped.
REQ-035 Count_o=3, simultaneous push+resolve -> count_o stays 3, one update pulse, correct head retired.
REQ-036 Resolve with empty queue -> no upd_valid_o, counters unchanged, err_o=1 and remains 1 until rst_i.
REQ-037 Count_o=5 with flush_i plus push same cycle -> count_o=0 next cycle, counters unchanged, no update pulse.
REQ-038 Force total_cnt_o to all-ones (CNT_W=4, 15 retires) then one more retire -> total_cnt_o stays 15.
